// File: rtl/led_matrix_scan_driver.sv
// Column-scan LED matrix driver: double-buffered ROWS x COLS frame, one-hot column
// strobe at a fixed slot rate, leading blank cycles per slot, valid/ready frame load.
module led_matrix_scan_driver #(
    parameter int unsigned ROWS  = 7,
    parameter int unsigned COLS  = 5,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load_valid,
    input  logic [ROWS*COLS-1:0]     load_data,
    output logic                     load_ready,
    output logic [COLS-1:0]          col_sel,
    output logic [$clog2(COLS)-1:0]  col_index,
    output logic [ROWS-1:0]          row_out,
    output logic                     frame_start
);

    localparam int unsigned CIW = $clog2(COLS);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned FW  = ROWS * COLS;

    logic [FW-1:0]   active, shadow;
    logic            pending, running;
    logic [CW-1:0]   cnt;
    logic [CIW-1:0]  col;

    logic [FW-1:0]   active_n, shadow_n;
    logic            pending_n, running_n;
    logic [CW-1:0]   cnt_n;
    logic [CIW-1:0]  col_n;
    logic            frame_start_n;
    logic [COLS-1:0] col_sel_n;
    logic [ROWS-1:0] row_n;
    logic            tick, wrap, xfer, lit;

    // Next scan state; outputs are derived from the post-edge state so they
    // change on the same edge as the counters and buffers they reflect.
    always_comb begin
        active_n      = active;
        shadow_n      = shadow;
        pending_n     = pending;
        running_n     = running;
        cnt_n         = cnt;
        col_n         = col;
        frame_start_n = 1'b0;
        col_sel_n     = '0;
        row_n         = '0;

        tick = (cnt == CW'(DIV - 1));
        wrap = running && tick && (col == CIW'(COLS - 1));
        xfer = load_valid && load_ready;

        if (xfer) begin
            shadow_n  = load_data;
            pending_n = 1'b1;
        end

        if (!enable) begin
            // Display off: park the scan and flush any waiting frame.
            running_n = 1'b0;
            cnt_n     = '0;
            col_n     = '0;
            if (pending) begin
                active_n  = shadow;
                pending_n = 1'b0;
            end
        end else if (!running) begin
            // First enabled cycle: column 0, blank phase first.
            running_n     = 1'b1;
            cnt_n         = '0;
            col_n         = '0;
            frame_start_n = 1'b1;
        end else begin
            cnt_n = tick ? '0 : cnt + 1'b1;
            if (tick) begin
                col_n = (col == CIW'(COLS - 1)) ? '0 : col + 1'b1;
            end
            frame_start_n = wrap;
            // Swap only at the frame boundary so a frame is never torn.
            if (wrap && pending) begin
                active_n  = shadow;
                pending_n = 1'b0;
            end
        end

        lit = (BLANK == 0) || (cnt_n >= CW'(BLANK));
        for (int c = 0; c < COLS; c++) begin
            if (col_n == CIW'(c)) begin
                col_sel_n[c] = enable;
                if (enable && lit) begin
                    row_n = active_n[c*ROWS +: ROWS];
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active      <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            running     <= 1'b0;
            cnt         <= '0;
            col         <= '0;
            load_ready  <= 1'b1;
            col_sel     <= '0;
            col_index   <= '0;
            row_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            active      <= active_n;
            shadow      <= shadow_n;
            pending     <= pending_n;
            running     <= running_n;
            cnt         <= cnt_n;
            col         <= col_n;
            load_ready  <= !pending_n;
            col_sel     <= col_sel_n;
            col_index   <= col_n;
            row_out     <= row_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Scoreboard bench for led_matrix_scan_driver: stimulus pushes per-cycle expected
// outputs, a monitor pops and compares them at the falling edge.
module tb_led_matrix_scan_driver;

    localparam int ROWS  = 7;
    localparam int COLS  = 5;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int SLOTS = DIV * COLS;

    localparam logic [34:0] F1 = 35'h55 << 14;
    localparam logic [34:0] F2 = 35'h2A | (35'h7F << 28);
    localparam logic [34:0] F3 = (35'h11 << 7) | (35'h66 << 21);
    localparam logic [34:0] F4 = 35'h7F | (35'h08 << 14);
    localparam logic [34:0] F5 = (35'h3C << 7) | (35'h01 << 21);

    typedef struct packed {
        logic [COLS-1:0] cs;
        logic [2:0]      ci;
        logic [ROWS-1:0] ro;
        logic            fs;
        logic            lr;
    } obs_t;

    typedef struct {
        obs_t  o;
        string tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic [34:0] load_data;
    logic        load_ready;
    logic [4:0]  col_sel;
    logic [2:0]  col_index;
    logic [6:0]  row_out;
    logic        frame_start;

    led_matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .col_sel    (col_sel),
        .col_index  (col_index),
        .row_out    (row_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    event        chk_ev;
    int          pos;
    logic [34:0] disp;
    logic        exp_rdy;
    string       phase;
    ent_t        cur;
    obs_t        act;

    function automatic obs_t expect_at(int p, logic [34:0] f, logic rdy);
        obs_t e;
        int   c;
        int   k;
        e    = '0;
        e.lr = rdy;
        if (p >= 0) begin
            c    = (p / DIV) % COLS;
            k    = p % DIV;
            e.cs = 5'(1) << c;
            e.ci = 3'(c);
            e.ro = (k >= BLANK) ? f[c*ROWS +: ROWS] : 7'h00;
            e.fs = (p == 0);
        end
        return e;
    endfunction

    // One clock: record what the DUT must show after this edge.
    task automatic step();
        @(posedge clk);
        sb.push_back('{o: expect_at(pos, disp, exp_rdy), tag: phase});
        if (pos >= 0) pos = (pos + 1) % SLOTS;
        #2;
    endtask

    task automatic run_to(input int p);
        while (pos != p) step();
    endtask

    // Monitor: compare each recorded expectation against the live outputs.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                act = '{cs: col_sel, ci: col_index, ro: row_out, fs: frame_start, lr: load_ready};
                total++;
                if (act !== cur.o) begin
                    bad++;
                    $display("FAIL %s t=%0t got cs=%b ci=%0d row=%h fs=%b rdy=%b want cs=%b ci=%0d row=%h fs=%b rdy=%b",
                             cur.tag, $time, act.cs, act.ci, act.ro, act.fs, act.lr,
                             cur.o.cs, cur.o.ci, cur.o.ro, cur.o.fs, cur.o.lr);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        pos        = -1;
        disp       = '0;
        exp_rdy    = 1'b1;

        phase = "reset_state";
        step();
        step();
        reset = 1'b0;
        phase = "idle_dark";
        step();

        phase = "empty_scan";
        enable = 1'b1;
        pos    = 0;
        repeat (SLOTS + 1) step();

        phase = "load_col3";
        run_to(13);
        load_valid = 1'b1;
        load_data  = F1;
        exp_rdy    = 1'b0;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        phase = "hold_until_wrap";
        run_to(0);
        phase = "show_f1";
        disp    = F1;
        exp_rdy = 1'b1;
        repeat (SLOTS) step();

        phase = "busy_reject";
        step();
        load_valid = 1'b1;
        load_data  = F2;
        exp_rdy    = 1'b0;
        step();
        load_data = F3;
        run_to(0);
        phase = "swap_f2";
        disp    = F2;
        exp_rdy = 1'b1;
        step();
        exp_rdy = 1'b0;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        phase = "f3_waiting";
        run_to(0);
        phase = "swap_f3";
        disp    = F3;
        exp_rdy = 1'b1;
        step();

        phase = "pre_wrap";
        run_to(0);
        phase = "load_on_wrap";
        load_valid = 1'b1;
        load_data  = F4;
        exp_rdy    = 1'b0;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        run_to(0);
        phase = "swap_f4";
        disp    = F4;
        exp_rdy = 1'b1;
        step();

        phase = "disable_flush";
        load_valid = 1'b1;
        load_data  = F5;
        exp_rdy    = 1'b0;
        step();
        load_valid = 1'b0;
        load_data  = '0;
        run_to(14);
        enable  = 1'b0;
        pos     = -1;
        disp    = F5;
        exp_rdy = 1'b1;
        step();
        step();
        phase = "reenable_f5";
        enable = 1'b1;
        pos    = 0;
        repeat (SLOTS) step();

        phase = "pre_reset";
        run_to(7);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.push_back('{o: expect_at(-1, '0, 1'b1), tag: "async_reset"});
        -> chk_ev;
        #1;
        phase   = "in_reset";
        pos     = -1;
        disp    = '0;
        exp_rdy = 1'b1;
        step();
        step();
        reset = 1'b0;
        phase = "post_reset_dark";
        pos   = 0;
        repeat (SLOTS) step();

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending expectations want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
